// File: rtl/match_controller.sv
// Referee FSM for a two-board best-of-ROUNDS snake match: start handshake, score latching, round compare, LED results.
// Optional macro PEER_TIMEOUT_EN: a peer that never finishes forfeits the round after TIMEOUT_CYCLES.
module match_controller #(
    parameter int unsigned ROUNDS      = 3,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned HOLD_CYCLES = 65000000
`ifdef PEER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 650000000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               local_ready,
    input  logic               remote_ready,
    input  logic               local_over,
    input  logic               remote_over,
    input  logic [SCORE_W-1:0] score,
    input  logic [SCORE_W-1:0] r_score,
    output logic               game_run,
    output logic               game_clear,
    output logic [3:0]         round_no,
    output logic [3:0]         local_wins,
    output logic [3:0]         remote_wins,
    output logic               result_valid,
    output logic [1:0]         round_result,
    output logic               match_over,
    output logic [15:0]        led
);

    localparam int unsigned HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned WIN_NEED = ROUNDS / 2 + 1;
`ifdef PEER_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_LOCAL  = 2'b01;
    localparam logic [1:0] RES_REMOTE = 2'b10;
    localparam logic [1:0] RES_DRAW   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PLAY,
        WAIT_PEER,
        COMPARE,
        SHOW,
        DONE
    } state_t;

    state_t              state, state_d;
    logic                game_run_d, game_clear_d, result_valid_d, match_over_d;
    logic [3:0]          round_no_d, local_wins_d, remote_wins_d;
    logic [1:0]          round_result_d, cmp_res;
    logic [15:0]         led_d;
    logic [SCORE_W-1:0]  loc_score, loc_score_d, rem_score, rem_score_d;
    logic                loc_done, loc_done_d, rem_done, rem_done_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
    logic                decided;
`ifdef PEER_TIMEOUT_EN
    logic [TO_W-1:0]     to_cnt, to_cnt_d;
    logic                forced, forced_d;
`endif

    // State, outputs and round bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            game_run     <= 1'b0;
            game_clear   <= 1'b0;
            round_no     <= 4'd0;
            local_wins   <= 4'd0;
            remote_wins  <= 4'd0;
            result_valid <= 1'b0;
            round_result <= RES_NONE;
            match_over   <= 1'b0;
            led          <= 16'h0000;
            loc_score    <= '0;
            rem_score    <= '0;
            loc_done     <= 1'b0;
            rem_done     <= 1'b0;
            hold_cnt     <= '0;
`ifdef PEER_TIMEOUT_EN
            to_cnt       <= '0;
            forced       <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            game_run     <= game_run_d;
            game_clear   <= game_clear_d;
            round_no     <= round_no_d;
            local_wins   <= local_wins_d;
            remote_wins  <= remote_wins_d;
            result_valid <= result_valid_d;
            round_result <= round_result_d;
            match_over   <= match_over_d;
            led          <= led_d;
            loc_score    <= loc_score_d;
            rem_score    <= rem_score_d;
            loc_done     <= loc_done_d;
            rem_done     <= rem_done_d;
            hold_cnt     <= hold_cnt_d;
`ifdef PEER_TIMEOUT_EN
            to_cnt       <= to_cnt_d;
            forced       <= forced_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d        = state;
        round_no_d     = round_no;
        local_wins_d   = local_wins;
        remote_wins_d  = remote_wins;
        round_result_d = round_result;
        match_over_d   = match_over;
        loc_score_d    = loc_score;
        rem_score_d    = rem_score;
        loc_done_d     = loc_done;
        rem_done_d     = rem_done;
        hold_cnt_d     = hold_cnt;
        decided        = (local_wins >= 4'(WIN_NEED)) || (remote_wins >= 4'(WIN_NEED)) ||
                         (round_no == 4'(ROUNDS));
        cmp_res        = (loc_score > rem_score) ? RES_LOCAL :
                         (loc_score < rem_score) ? RES_REMOTE : RES_DRAW;
`ifdef PEER_TIMEOUT_EN
        to_cnt_d       = '0;
        forced_d       = forced;
        if (forced) cmp_res = loc_done ? RES_LOCAL : RES_REMOTE;
`endif

        case (state)
            IDLE: begin
                if (local_ready && remote_ready) state_d = CLEAR;
            end
            CLEAR: begin
                loc_score_d = '0;
                rem_score_d = '0;
                loc_done_d  = 1'b0;
                rem_done_d  = 1'b0;
                state_d     = PLAY;
            end
            PLAY, WAIT_PEER: begin
                // Each side's score is captured only on its first over
                if (local_over && !loc_done) begin
                    loc_score_d = score;
                    loc_done_d  = 1'b1;
                end
                if (remote_over && !rem_done) begin
                    rem_score_d = r_score;
                    rem_done_d  = 1'b1;
                end
                if (loc_done_d && rem_done_d)      state_d = COMPARE;
                else if (loc_done_d || rem_done_d) state_d = WAIT_PEER;
`ifdef PEER_TIMEOUT_EN
                if (state == WAIT_PEER && !(loc_done_d && rem_done_d)) begin
                    if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        forced_d = 1'b1;
                        state_d  = COMPARE;
                    end else begin
                        to_cnt_d = to_cnt + 1'b1;
                    end
                end
`endif
            end
            COMPARE: begin
                round_result_d = cmp_res;
                if (cmp_res == RES_LOCAL)  local_wins_d  = local_wins + 4'd1;
                if (cmp_res == RES_REMOTE) remote_wins_d = remote_wins + 4'd1;
                round_no_d = round_no + 4'd1;
                hold_cnt_d = '0;
`ifdef PEER_TIMEOUT_EN
                forced_d   = 1'b0;
`endif
                state_d    = SHOW;
            end
            SHOW: begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    round_result_d = RES_NONE;
                    if (decided) begin
                        match_over_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        state_d      = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            DONE: begin
                if (local_ready && remote_ready) begin
                    round_no_d    = 4'd0;
                    local_wins_d  = 4'd0;
                    remote_wins_d = 4'd0;
                    match_over_d  = 1'b0;
                    state_d       = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase

        game_run_d     = (state_d == PLAY) || (state_d == WAIT_PEER);
        game_clear_d   = (state_d == CLEAR);
        result_valid_d = (state_d == SHOW);

        // LED pattern follows the current state, so it lags a state change by one cycle
        case (state)
            SHOW: begin
                case (round_result)
                    RES_LOCAL: led_d = 16'hFFFF;
                    RES_DRAW:  led_d = 16'hFF00;
                    default:   led_d = 16'h0000;
                endcase
            end
            DONE: begin
                if (local_wins > remote_wins)       led_d = 16'hFFFF;
                else if (local_wins == remote_wins) led_d = 16'hAAAA;
                else                                led_d = 16'h0000;
            end
            default: led_d = {local_wins, 8'h00, remote_wins};
        endcase
    end

endmodule

// File: tb/tb_match_controller.sv
// Directed self-checking bench for match_controller (ROUNDS=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=8).
module tb_match_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        local_ready, remote_ready, local_over, remote_over;
    logic [3:0]  score, r_score;
    logic        game_run, game_clear, result_valid, match_over;
    logic [3:0]  round_no, local_wins, remote_wins;
    logic [1:0]  round_result;
    logic [15:0] led;

    int checks = 0;
    int passed = 0;

    match_controller #(
        .ROUNDS(3),
        .SCORE_W(4),
        .HOLD_CYCLES(4)
`ifdef PEER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .local_ready(local_ready),
        .remote_ready(remote_ready),
        .local_over(local_over),
        .remote_over(remote_over),
        .score(score),
        .r_score(r_score),
        .game_run(game_run),
        .game_clear(game_clear),
        .round_no(round_no),
        .local_wins(local_wins),
        .remote_wins(remote_wins),
        .result_valid(result_valid),
        .round_result(round_result),
        .match_over(match_over),
        .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        local_ready = 1'b0; remote_ready = 1'b0;
        local_over = 1'b0;  remote_over = 1'b0;
        score = 4'd0;       r_score = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Handshake from IDLE/DONE; returns at the first PLAY negedge
    task automatic start_round();
        local_ready = 1'b1; remote_ready = 1'b1;
        @(negedge clk);
        local_ready = 1'b0; remote_ready = 1'b0;
        @(negedge clk);
    endtask

    // Local finishes first, remote 3 cycles later; returns at the COMPARE negedge
    task automatic play_round(input logic [3:0] ls, input logic [3:0] rs);
        score = ls; local_over = 1'b1;
        @(negedge clk);
        local_over = 1'b0;
        repeat (2) @(negedge clk);
        r_score = rs; remote_over = 1'b1;
        @(negedge clk);
        remote_over = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({game_run, game_clear, round_no, local_wins, remote_wins, result_valid,
             round_result, match_over, led} !== 33'd0)
            $display("FAIL reset_outputs: got run=%b clr=%b rn=%0d lw=%0d rw=%0d rv=%b rr=%b mo=%b led=%h, want all 0",
                     game_run, game_clear, round_no, local_wins, remote_wins, result_valid,
                     round_result, match_over, led);
        else passed++;
        local_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (game_run !== 1'b0 || game_clear !== 1'b0 || led !== 16'h0000)
                $display("FAIL idle_one_ready: cycle %0d run=%b clr=%b led=%h, want 0 0 0000",
                         i, game_run, game_clear, led);
            else passed++;
        end
    endtask

    task automatic test_start();
        remote_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (game_clear !== 1'b1 || game_run !== 1'b0)
            $display("FAIL start_clear: clr=%b run=%b, want 1 0", game_clear, game_run);
        else passed++;
        local_ready = 1'b0; remote_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (game_clear !== 1'b0 || game_run !== 1'b1)
            $display("FAIL start_play: clr=%b run=%b, want 0 1", game_clear, game_run);
        else passed++;
    endtask

    task automatic test_local_win();
        int rv_cnt;
        play_round(4'd7, 4'd5);
        checks++;
        if (result_valid !== 1'b0 || game_run !== 1'b0)
            $display("FAIL win_compare_cycle: rv=%b run=%b, want 0 0", result_valid, game_run);
        else passed++;
        rv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) rv_cnt++;
            if (i == 0) begin
                checks++;
                if (round_result !== 2'b01 || local_wins !== 4'd1 || remote_wins !== 4'd0 ||
                    round_no !== 4'd1)
                    $display("FAIL win_result: rr=%b lw=%0d rw=%0d rn=%0d, want 01 1 0 1",
                             round_result, local_wins, remote_wins, round_no);
                else passed++;
            end
            if (i == 1) begin
                checks++;
                if (led !== 16'hFFFF) $display("FAIL win_led_show: led=%h, want ffff", led);
                else passed++;
            end
        end
        checks++;
        if (rv_cnt != 4) $display("FAIL win_hold: result_valid high %0d cycles, want 4", rv_cnt);
        else passed++;
        checks++;
        if (led !== 16'h1000 || round_result !== 2'b00 || game_run !== 1'b0)
            $display("FAIL win_idle: led=%h rr=%b run=%b, want 1000 00 0", led, round_result, game_run);
        else passed++;
    endtask

    task automatic test_draw();
        do_reset();
        start_round();
        score = 4'd3; r_score = 4'd3;
        local_over = 1'b1; remote_over = 1'b1;
        @(negedge clk);
        local_over = 1'b0; remote_over = 1'b0;
        checks++;
        if (game_run !== 1'b0 || result_valid !== 1'b0)
            $display("FAIL draw_compare_cycle: run=%b rv=%b, want 0 0", game_run, result_valid);
        else passed++;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || round_result !== 2'b11 || local_wins !== 4'd0 ||
            remote_wins !== 4'd0 || round_no !== 4'd1)
            $display("FAIL draw_result: rv=%b rr=%b lw=%0d rw=%0d rn=%0d, want 1 11 0 0 1",
                     result_valid, round_result, local_wins, remote_wins, round_no);
        else passed++;
        @(negedge clk);
        checks++;
        if (led !== 16'hFF00) $display("FAIL draw_led: led=%h, want ff00", led);
        else passed++;
    endtask

    task automatic test_latch_hold();
        do_reset();
        start_round();
        score = 4'd2; local_over = 1'b1;
        @(negedge clk);
        score = 4'd9;
        repeat (2) @(negedge clk);
        r_score = 4'd4; remote_over = 1'b1;
        @(negedge clk);
        remote_over = 1'b0; local_over = 1'b0;
        @(negedge clk);
        checks++;
        if (round_result !== 2'b10 || remote_wins !== 4'd1 || local_wins !== 4'd0)
            $display("FAIL latch_result: rr=%b lw=%0d rw=%0d, want 10 0 1",
                     round_result, local_wins, remote_wins);
        else passed++;
        @(negedge clk);
        checks++;
        if (led !== 16'h0000) $display("FAIL latch_led: led=%h, want 0000", led);
        else passed++;
    endtask

    task automatic test_match_done();
        do_reset();
        start_round();
        play_round(4'd7, 4'd5);
        repeat (5) @(negedge clk);
        checks++;
        if (match_over !== 1'b0 || round_no !== 4'd1 || result_valid !== 1'b0)
            $display("FAIL match_round1: mo=%b rn=%0d rv=%b, want 0 1 0", match_over, round_no, result_valid);
        else passed++;
        start_round();
        play_round(4'd6, 4'd1);
        repeat (5) @(negedge clk);
        checks++;
        if (match_over !== 1'b1 || round_no !== 4'd2 || local_wins !== 4'd2 || result_valid !== 1'b0)
            $display("FAIL match_done: mo=%b rn=%0d lw=%0d rv=%b, want 1 2 2 0",
                     match_over, round_no, local_wins, result_valid);
        else passed++;
        repeat (2) @(negedge clk);
        checks++;
        if (led !== 16'hFFFF || match_over !== 1'b1)
            $display("FAIL match_led: led=%h mo=%b, want ffff 1", led, match_over);
        else passed++;
        local_ready = 1'b1; remote_ready = 1'b1;
        @(negedge clk);
        local_ready = 1'b0; remote_ready = 1'b0;
        checks++;
        if (game_clear !== 1'b1 || local_wins !== 4'd0 || remote_wins !== 4'd0 ||
            round_no !== 4'd0 || match_over !== 1'b0)
            $display("FAIL match_restart: clr=%b lw=%0d rw=%0d rn=%0d mo=%b, want 1 0 0 0 0",
                     game_clear, local_wins, remote_wins, round_no, match_over);
        else passed++;
    endtask

    task automatic test_peer_timeout();
        int bad;
        do_reset();
        start_round();
        score = 4'd1; local_over = 1'b1;
        @(negedge clk);
        local_over = 1'b0;
`ifdef PEER_TIMEOUT_EN
        repeat (7) @(negedge clk);
        checks++;
        if (game_run !== 1'b1) $display("FAIL timeout_wait: run=%b, want 1", game_run);
        else passed++;
        @(negedge clk);
        checks++;
        if (game_run !== 1'b0) $display("FAIL timeout_compare: run=%b, want 0", game_run);
        else passed++;
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || round_result !== 2'b01 || local_wins !== 4'd1)
            $display("FAIL timeout_result: rv=%b rr=%b lw=%0d, want 1 01 1",
                     result_valid, round_result, local_wins);
        else passed++;
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (game_run !== 1'b1 || result_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) $display("FAIL wait_forever: %0d cycles left WAIT_PEER, want 0", bad);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        start_round();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({game_run, game_clear, round_no, local_wins, remote_wins, result_valid,
             round_result, match_over, led} !== 33'd0)
            $display("FAIL reset_mid_play: run=%b clr=%b rn=%0d led=%h, want all 0",
                     game_run, game_clear, round_no, led);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_local_win();
        test_draw();
        test_latch_hold();
        test_match_done();
        test_peer_timeout();
        test_reset_mid_play();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Referee FSM for a two-board multiplayer snake match, played best-of-ROUNDS.
- Start handshake: both players must be ready before a round begins.
- Per round: enables/clears local game logic, latches local and remote final scores as each player finishes, compares them, tallies wins.
- Drives the 16-bit LED bank with round and match results.
- Sits between the local game core, the inter-board link (inputs already synchronized) and the board LEDs.

Parameters:
- ROUNDS, 3, rounds per match (odd, 1..15).
- SCORE_W, 4, score width in bits.
- HOLD_CYCLES, 65000000, cycles a round result is displayed (1 s at 65 MHz).
- TIMEOUT_CYCLES, 650000000, peer-finish timeout; used only with PEER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- local_ready  in  1  local player ready (level).
- remote_ready  in  1  remote player ready (level, synchronized).
- local_over  in  1  local game over (level or pulse).
- remote_over  in  1  remote game over (level or pulse, synchronized).
- score  in  SCORE_W  local live score.
- r_score  in  SCORE_W  remote live score.
- game_run  out  1  enables local game core.
- game_clear  out  1  one-cycle pulse to clear game core at round start.
- round_no  out  4  completed rounds in current match.
- local_wins  out  4  rounds won locally.
- remote_wins  out  4  rounds won remotely.
- result_valid  out  1  high while a round result is shown.
- round_result  out  2  00 none, 01 local, 10 remote, 11 draw.
- match_over  out  1  match decided.
- led  out  16  LED bank.

Behaviour:
- Clock, reset, registers: one clock, clk. reset is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE; all outputs 0; latches and counters 0.
- IDLE: game_run=0. local_ready & remote_ready both 1 in the same cycle -> CLEAR.
- CLEAR: exactly one cycle, game_clear=1. Clears both score latches and both done flags -> PLAY.
- PLAY/WAIT_PEER: game_run=1.
  - First cycle local_over=1: latch score, set loc_done.
  - First cycle remote_over=1: latch r_score, set rem_done.
  - Later over assertions are ignored; latches never re-load within a round.
  - Exactly one done flag set -> WAIT_PEER.
  - Both done (including both over in the same cycle) -> COMPARE.
- COMPARE: one cycle, unsigned compare of the latched scores.
  - loc > rem: local_wins+1, result 01.
  - loc < rem: remote_wins+1, result 10.
  - Equal: draw, result 11, no win increment.
  - round_no+1.
- Latency: both-done seen in cycle N -> COMPARE in N+1 -> SHOW in N+2. In N+2 result_valid=1 and updated counters are visible.
- SHOW: holds result_valid and round_result for exactly HOLD_CYCLES cycles, then:
  - Match decided -> DONE, match_over=1.
  - Otherwise -> IDLE, result_valid=0, round_result=00.
  - Decided means either wins count ≥ ROUNDS/2+1, or round_no = ROUNDS.
- DONE: holds counters and match_over. local_ready & remote_ready both 1 -> counters/round_no/match_over cleared, -> CLEAR (new match).
- Ready held high: rounds auto-start after SHOW. This is intended behaviour.
- LED outputs:
  - SHOW: FFFF local round win, FF00 draw, 0000 remote win.
  - DONE: FFFF if local_wins > remote_wins, AAAA if equal, 0000 if less.
  - Other states: led[15:12]=local_wins, led[3:0]=remote_wins, remaining bits 0.
  - led updates one cycle after state/counter change.
- reset mid-round (any state): immediate return to reset values, game_run drops asynchronously.
- Counters never wrap: round_no saturates at ROUNDS by construction.

Optional Feature:
- Macro PEER_TIMEOUT_EN.
- Defined: WAIT_PEER counts cycles. If the missing player has not finished after TIMEOUT_CYCLES, that player forfeits:
  - The finished side wins the round (01 or 10).
  - -> COMPARE path with forced result.
  - Counter clears on leaving WAIT_PEER.
- Undefined: WAIT_PEER waits indefinitely. No counter logic is synthesized.

Test Plan (ROUNDS=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=8):
- Reset, then local_ready=1 with remote_ready=0 for 20 cycles -> stays IDLE, game_run=0, led=0000. Both ready -> game_clear pulses one cycle, game_run=1.
- Round: local_over with score=7, later remote_over with r_score=5 -> round_result=01, local_wins=1, result_valid high exactly 4 cycles, led=FFFF in SHOW, then led=1000.
- Both over in the same cycle with score=r_score=3 -> COMPARE next cycle, result 11, led=FF00, no win increment, round_no=1.
- Score changes after over: local_over with score=2, then score goes to 9 before remote_over with r_score=4 -> result 10 (latched 2 used).
- Local wins rounds 1 and 2 -> after second SHOW, DONE with match_over=1, led=FFFF, round_no=2. Both ready -> counters 0, game_clear pulse.
- PEER_TIMEOUT_EN: local_over only, remote silent 8 cycles in WAIT_PEER -> result 01. Without the macro, stays in WAIT_PEER for 100 cycles. Reset asserted mid-PLAY -> all outputs 0 immediately.
